// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - load/store initiator with sub-word RMW for a single-port RAM
// Optional MEM_PORT_MISALIGN_CHK_EN: misalignment detection and error response.
module mem_port_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    typedef enum logic [2:0] {IDLE, ACCESS, LOAD_WAIT, MERGE, WRITE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic [1:0]        size_eff;
    logic              misalign;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign req_ready   = (state_q == IDLE) && reset_n;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;

`ifdef MEM_PORT_MISALIGN_CHK_EN
    assign size_eff = req_size;
    assign misalign = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    assign size_eff = (req_size == 2'b11) ? SZ_WORD : req_size;
    assign misalign = 1'b0;
`endif

    // Lane extraction and merge both work on the word the RAM just returned.
    always_comb begin
        byte_sel = 8'h00;
        case (lane_q)
            2'd0: byte_sel = mem_q[7:0];
            2'd1: byte_sel = mem_q[15:8];
            2'd2: byte_sel = mem_q[23:16];
            default: byte_sel = mem_q[31:24];
        endcase
        half_sel = lane_q[1] ? mem_q[31:16] : mem_q[15:0];
        case (size_q)
            SZ_BYTE: load_val = {{24{sgn_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{sgn_q & half_sel[15]}}, half_sel};
            default: load_val = mem_q;
        endcase
        merged = mem_q;
        if (size_q == SZ_BYTE)
            merged[{lane_q, 3'b000} +: 8] = mem_data_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = mem_data_q[15:0];
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        lane_d        = lane_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misalign) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        state_d       = ACCESS;
                        we_d          = req_we;
                        size_d        = size_eff;
                        sgn_d         = req_signed;
                        lane_d        = req_addr[1:0];
                        mem_address_d = req_addr[ADDR_W+1:2];
                        mem_data_d    = req_wdata;
                        mem_wren_d    = req_we && (size_eff == SZ_WORD);
                    end
                end
            end
            ACCESS: begin
                if (we_q && size_q == SZ_WORD) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    state_d     = IDLE;
                end else if (!we_q) begin
                    state_d = LOAD_WAIT;
                end else begin
                    state_d = MERGE;
                end
            end
            LOAD_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_val;
                state_d     = IDLE;
            end
            MERGE: begin
                mem_data_d = merged;
                mem_wren_d = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            sgn_q         <= 1'b0;
            lane_q        <= 2'b00;
            mem_address_q <= '0;
            mem_data_q    <= 32'h0;
            mem_wren_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            lane_q        <= lane_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - randomized self-checking bench for mem_port_ctrl with a byte-array memory model
module tb_mem_port_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    int tests = 0;
    int fails = 0;

    logic [31:0] ram [0:65535];
    logic [7:0]  shadow [0:1023];

    always #5 clock = ~clock;

    // RAM: 1-cycle registered read, write-first
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= mem_wren ? mem_data : ram[mem_address];
    end

    mem_port_ctrl #(.ADDR_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // Reference: byte-addressed little-endian memory; updates shadow on stores.
    function automatic void model(input bit we, input logic [1:0] size, input bit sgn,
                                  input logic [17:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] er, output bit ee, output int el);
        int nb;
        int base;
        bit mis;
        logic [31:0] v;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`ifdef MEM_PORT_MISALIGN_CHK_EN
        mis = (size == 2'b11) || (int'(addr) % nb != 0);
`else
        mis = 1'b0;
`endif
        er = 32'h0;
        ee = 1'b0;
        if (mis) begin
            ee = 1'b1;
            el = 1;
            return;
        end
        base = int'(addr) - (int'(addr) % nb);
        if (we) begin
            for (int i = 0; i < nb; i++) shadow[base + i] = wdata[8*i +: 8];
            el = (nb == 4) ? 2 : 4;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(shadow[base + i]) << (8 * i));
            if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            er = v;
            el = 3;
        end
    endfunction

    task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                          input logic [17:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wrens, output logic [31:0] wdat, output logic [15:0] aseen,
                          output bit dbl, output bit extra);
        int guard;
        bit prev;
        @(negedge clock);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL req_ready_timeout got=0 exp=1");
        end
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1; wrens = 0; dbl = 0; prev = 0; wdat = 32'h0;
        aseen = mem_address;
        while (!rsp_valid && lat < 10) begin
            if (mem_wren) begin wrens++; wdat = mem_data; if (prev) dbl = 1; end
            prev = mem_wren;
            @(negedge clock);
            lat++;
        end
        if (mem_wren) begin wrens++; if (prev) dbl = 1; end
        rdata = rsp_rdata;
        err = rsp_err;
        @(negedge clock);
        extra = rsp_valid;
    endtask

    logic [31:0] g_rd, g_wd, e_rd;
    logic        g_err;
    bit          e_err, g_dbl, g_extra;
    int          g_lat, g_wr, e_lat;
    logic [15:0] g_as;

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        tests++;
        if ({req_ready, rsp_valid, rsp_err, mem_wren} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got ready=%b rv=%b re=%b wren=%b exp all 0",
                     req_ready, rsp_valid, rsp_err, mem_wren);
        end
        tests++;
        if ({rsp_rdata, mem_data, mem_address} !== 80'h0) begin
            fails++;
            $display("FAIL reset_values got rdata=%h data=%h addr=%h exp 0", rsp_rdata, mem_data, mem_address);
        end
        reset_n = 1'b1;
        @(negedge clock);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_word;
        model(1, 2'b10, 0, 18'h10, 32'hDEADBEEF, e_rd, e_err, e_lat);
        do_req(1, 2'b10, 0, 18'h10, 32'hDEADBEEF, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        tests++;
        if ({g_lat, g_err, g_wr, g_as} !== {32'd2, 1'b0, 32'd1, 16'h0004}) begin
            fails++;
            $display("FAIL word_store got lat=%0d err=%b wrens=%0d addr=%h exp lat=2 err=0 wrens=1 addr=0004",
                     g_lat, g_err, g_wr, g_as);
        end
        model(0, 2'b10, 0, 18'h10, 0, e_rd, e_err, e_lat);
        do_req(0, 2'b10, 0, 18'h10, 0, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        tests++;
        if ({g_lat, g_err, g_rd, g_wr} !== {32'd3, 1'b0, 32'hDEADBEEF, 32'd0}) begin
            fails++;
            $display("FAIL word_load got lat=%0d err=%b rdata=%h wrens=%0d exp lat=3 err=0 rdata=deadbeef wrens=0",
                     g_lat, g_err, g_rd, g_wr);
        end
    endtask

    task automatic test_subword;
        logic [17:0] la [5];
        logic [1:0]  ls [5];
        bit          lg [5];
        logic [31:0] lx [5];
        model(1, 2'b10, 0, 18'h10, 32'h11223344, e_rd, e_err, e_lat);
        do_req(1, 2'b10, 0, 18'h10, 32'h11223344, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        model(1, 2'b00, 0, 18'h11, 32'h000000AA, e_rd, e_err, e_lat);
        do_req(1, 2'b00, 0, 18'h11, 32'h000000AA, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        tests++;
        if ({g_lat, g_wr, g_wd, g_dbl, g_extra} !== {32'd4, 32'd1, 32'h1122AA44, 2'b00}) begin
            fails++;
            $display("FAIL byte_store got lat=%0d wrens=%0d wdata=%h dbl=%b extra=%b exp lat=4 wrens=1 wdata=1122aa44 dbl=0 extra=0",
                     g_lat, g_wr, g_wd, g_dbl, g_extra);
        end
        la = '{18'h10, 18'h11, 18'h11, 18'h12, 18'h10};
        ls = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
        lg = '{0, 1, 0, 1, 0};
        lx = '{32'h1122AA44, 32'hFFFFFFAA, 32'h000000AA, 32'h00001122, 32'h1122BEEF};
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                model(1, 2'b01, 0, 18'h10, 32'h0000BEEF, e_rd, e_err, e_lat);
                do_req(1, 2'b01, 0, 18'h10, 32'h0000BEEF, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
                tests++;
                if ({g_lat, g_wd} !== {32'd4, 32'h1122BEEF}) begin
                    fails++;
                    $display("FAIL half_store got lat=%0d wdata=%h exp lat=4 wdata=1122beef", g_lat, g_wd);
                end
            end
            model(0, ls[i], lg[i], la[i], 0, e_rd, e_err, e_lat);
            do_req(0, ls[i], lg[i], la[i], 0, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
            tests++;
            if ({g_lat, g_err, g_rd} !== {32'd3, 1'b0, lx[i]}) begin
                fails++;
                $display("FAIL subword_load[%0d] got lat=%0d err=%b rdata=%h exp lat=3 err=0 rdata=%h",
                         i, g_lat, g_err, g_rd, lx[i]);
            end
        end
    endtask

    task automatic test_misalign;
        logic [31:0] x_rd;
        int          x_lat;
        logic        x_err;
        model(0, 2'b01, 0, 18'h13, 0, e_rd, e_err, e_lat);
        do_req(0, 2'b01, 0, 18'h13, 0, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
`ifdef MEM_PORT_MISALIGN_CHK_EN
        x_lat = 1; x_err = 1'b1; x_rd = 32'h0;
`else
        x_lat = 3; x_err = 1'b0; x_rd = 32'h00001122;
`endif
        tests++;
        if ({g_lat, g_err, g_rd, g_wr, g_extra} !== {x_lat, x_err, x_rd, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL half_misalign got lat=%0d err=%b rdata=%h wrens=%0d extra=%b exp lat=%0d err=%b rdata=%h wrens=0 extra=0",
                     g_lat, g_err, g_rd, g_wr, g_extra, x_lat, x_err, x_rd);
        end
        model(1, 2'b11, 0, 18'h10, 32'h55667788, e_rd, e_err, e_lat);
        do_req(1, 2'b11, 0, 18'h10, 32'h55667788, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        tests++;
        if ({g_lat, g_err, g_wr} !== {e_lat, e_err, (e_err ? 32'd0 : 32'd1)}) begin
            fails++;
            $display("FAIL size11_store got lat=%0d err=%b wrens=%0d exp lat=%0d err=%b", g_lat, g_err, g_wr, e_lat, e_err);
        end
    endtask

    task automatic test_back_to_back;
        int ac [3];
        int rc [3];
        logic [31:0] rd [3];
        int na = 0;
        int nr = 0;
        model(0, 2'b10, 0, 18'h10, 0, e_rd, e_err, e_lat);
        @(negedge clock);
        req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 18'h10; req_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (rsp_valid) begin
                if (nr < 3) begin rc[nr] = c; rd[nr] = rsp_rdata; end
                nr++;
            end
            if (req_valid && req_ready) begin
                if (na < 3) ac[na] = c;
                na++;
            end
            @(negedge clock);
            if (na >= 3) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        tests++;
        if (na !== 3 || nr !== 3) begin
            fails++;
            $display("FAIL b2b_counts got accepts=%0d rsps=%0d exp 3 3", na, nr);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if ({ac[i], rc[i], rd[i]} !== {32'(3 * i), 32'(3 * i + 3), e_rd}) begin
                    fails++;
                    $display("FAIL b2b[%0d] got acc=%0d rsp=%0d rdata=%h exp acc=%0d rsp=%0d rdata=%h",
                             i, ac[i], rc[i], rd[i], 3 * i, 3 * i + 3, e_rd);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        @(negedge clock);
        req_we = 1; req_size = 2'b00; req_signed = 0; req_addr = 18'h11; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        seen = seen | rsp_valid;
        @(negedge clock);
        seen = seen | rsp_valid;
        reset_n = 1'b0;
        @(negedge clock);
        tests++;
        if ({seen, rsp_valid, rsp_err, mem_wren, req_ready, rsp_rdata, mem_data, mem_address} !== 85'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs got rsp=%b/%b err=%b wren=%b ready=%b rdata=%h data=%h addr=%h exp all 0",
                     seen, rsp_valid, rsp_err, mem_wren, req_ready, rsp_rdata, mem_data, mem_address);
        end
        reset_n = 1'b1;
        model(0, 2'b10, 0, 18'h10, 0, e_rd, e_err, e_lat);
        do_req(0, 2'b10, 0, 18'h10, 0, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        tests++;
        if ({g_lat, g_err, g_rd} !== {32'd3, 1'b0, e_rd}) begin
            fails++;
            $display("FAIL reset_mid_after got lat=%0d err=%b rdata=%h exp lat=3 err=0 rdata=%h", g_lat, g_err, g_rd, e_rd);
        end
    endtask

    task automatic test_random;
        logic [17:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        bit          we, sg;
        int          e_wr;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model(1, 2'b10, 0, 18'(4 * w), wd, e_rd, e_err, e_lat);
            do_req(1, 2'b10, 0, 18'(4 * w), wd, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
        end
        for (int n = 0; n < 80; n++) begin
            a  = 18'($urandom_range(0, 255));
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom);
            sg = 1'($urandom);
            wd = $urandom;
            model(we, sz, sg, a, wd, e_rd, e_err, e_lat);
            e_wr = (we && !e_err) ? 1 : 0;
            do_req(we, sz, sg, a, wd, g_rd, g_err, g_lat, g_wr, g_wd, g_as, g_dbl, g_extra);
            tests++;
            if ({g_lat, g_err, g_rd, g_wr, g_dbl, g_extra} !== {e_lat, e_err, e_rd, e_wr, 2'b00}
                || (!e_err && g_as !== a[17:2])) begin
                fails++;
                $display("FAIL rand[%0d] we=%b sz=%0d sg=%b a=%h got lat=%0d err=%b rdata=%h wrens=%0d dbl=%b extra=%b addr=%h exp lat=%0d err=%b rdata=%h wrens=%0d addr=%h",
                         n, we, sz, sg, a, g_lat, g_err, g_rd, g_wr, g_dbl, g_extra, g_as,
                         e_lat, e_err, e_rd, e_wr, a[17:2]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
        test_reset;
        test_word;
        test_subword;
        test_misalign;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
